// File: rtl/fib_pair_serializer.sv
// Buffers pairs of consecutive Fibonacci values and streams them out one per cycle,
// flagging any emitted value that breaks the recurrence and counting emitted values.
module fib_pair_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      emit_cnt,
  output logic             seq_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             phase;

  logic             push;
  logic             xfer;
  logic             pop;

  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] p2;
  logic [WIDTH-1:0] expect_val;
  logic [1:0]       hist;

  assign in_ready   = (occ != CW'(DEPTH));
  assign out_valid  = (occ != '0);
  assign push       = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign pop        = xfer && phase;
  assign expect_val = p1 + p2;

  // Head value select; phase picks the earlier or later half of the head pair.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = phase ? mem_b[rd_ptr] : mem_a[rd_ptr];
    end
  end

  // Pair storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      phase  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (xfer) phase  <= ~phase;
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Recurrence checker and saturating emit counter; the first two values seed the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1       <= '0;
      p2       <= '0;
      hist     <= '0;
      seq_err  <= 1'b0;
      emit_cnt <= '0;
    end else if (xfer) begin
      p1 <= out_data;
      p2 <= p1;
      if (hist != 2'd2) hist <= hist + 2'd1;
      if ((hist == 2'd2) && (out_data != expect_val)) seq_err <= 1'b1;
      if (emit_cnt != 16'hFFFF) emit_cnt <= emit_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Randomized and directed bench for fib_pair_serializer against a queue-based value model.
module tb_fib_pair_serializer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      emit_cnt;
  logic             seq_err;

  fib_pair_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .emit_cnt(emit_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Model: the stream of values still to be emitted, plus the emitted history.
  logic [15:0] q[$];
  logic [15:0] log_q[$];
  int          nemit = 0;
  logic [15:0] mp1 = '0;
  logic [15:0] mp2 = '0;
  bit          merr = 1'b0;
  bit          model_on = 1'b0;

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string name, input logic [15:0] exp[$]);
    check({name, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp[i]);
  endtask

  // One clock: compare outputs against the model mid-cycle, advance the model, step past the edge.
  task automatic tick();
    int          pairs;
    bit          xfer;
    bit          push;
    logic [15:0] v;
    logic [15:0] sum;
    @(negedge clk);
    pairs = (q.size() + 1) / 2;
    if (model_on) begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, pairs < DEPTH);
      check("out_data", out_data, (q.size() != 0) ? q[0] : 16'd0);
      check("emit_cnt", emit_cnt, (nemit > 65535) ? 65535 : nemit);
      check("seq_err", seq_err, merr);
    end
    if (rst) begin
      q.delete();
      nemit    = 0;
      merr     = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      xfer = (q.size() != 0) && out_ready;
      push = in_valid && (pairs < DEPTH);
      if (xfer) begin
        v   = q.pop_front();
        sum = mp1 + mp2;
        if (nemit >= 2 && v != sum) merr = 1'b1;
        mp2 = mp1;
        mp1 = v;
        nemit++;
        if (log_q.size() < 1000) log_q.push_back(v);
      end
      if (push) begin
        q.push_back(in_a);
        q.push_back(in_b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    guard    = 0;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    log_q.delete();
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] fa, fb, fc;
  bit          acc;

  initial begin
    // Reset with a handshake offered in the reset cycle; it must be ignored.
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; out_ready = 1'b1;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_emit_cnt", emit_cnt, 0);
    check("rst_seq_err", seq_err, 0);

    // Steady stream
    out_ready = 1'b1;
    push_pair(16'd1, 16'd1); idle(1);
    push_pair(16'd2, 16'd3); idle(1);
    push_pair(16'd5, 16'd8); idle(6);
    exp_q = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    check_seq("steady", exp_q);
    check("steady_emit_cnt", emit_cnt, 6);
    check("steady_seq_err", seq_err, 0);

    // Full FIFO and recovery after the first pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 16'(10 * i + 1); in_b = 16'(10 * i + 2);
      tick();
    end
    in_a = 16'd41; in_b = 16'd42;
    check("full_in_ready", in_ready, 0);
    tick();
    check("full_in_ready_held", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("full_after_xfer1", in_ready, 0);
    tick();
    check("full_after_pop", in_ready, 1);
    tick();
    idle(12);
    exp_q = '{16'd1, 16'd2, 16'd11, 16'd12, 16'd21, 16'd22, 16'd31, 16'd32, 16'd41, 16'd42};
    check_seq("full", exp_q);

    // Wrap-around arithmetic
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd28657, 16'd46368);
    push_pair(16'd9489, 16'd55857);
    idle(6);
    exp_q = '{16'd28657, 16'd46368, 16'd9489, 16'd55857};
    check_seq("wrap", exp_q);
    check("wrap_seq_err", seq_err, 0);

    // Error injection; flag must stick through later correct data
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd4);
    push_pair(16'd6, 16'd10);
    idle(8);
    check("err_seq_err", seq_err, 1);
    check("err_emit_cnt", emit_cnt, 6);

    // Backpressure with random valid/ready on a correct Fibonacci stream
    do_reset();
    exp_q.delete();
    fa = 16'd0; fb = 16'd1;
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_a = fa; in_b = fb;
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        exp_q.push_back(fa); exp_q.push_back(fb);
        fc = fa + fb; fa = fb + fc; fb = fc + fa;
        fa = fc; fb = fc + exp_q[exp_q.size() - 1];
      end
    end
    out_ready = 1'b1;
    idle(12);
    check_seq("bp", exp_q);
    check("bp_seq_err", seq_err, 0);

    // Fully random data and handshakes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = 16'($urandom); in_b = 16'($urandom);
      tick();
    end
    idle(10);

    // Mid-operation reset with buffered pairs, phase 1 and error set
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd4);
    push_pair(16'd9, 16'd9);
    push_pair(16'd9, 16'd9);
    out_ready = 1'b1; in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9;
    repeat (5) tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    check("mid_seq_err_pre", seq_err, 1);
    in_valid = 1'b1; out_ready = 1'b1;
    do_reset();
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_emit_cnt", emit_cnt, 0);
    check("mid_seq_err", seq_err, 0);
    push_pair(16'd100, 16'd7);
    idle(4);
    exp_q = '{16'd100, 16'd7};
    check_seq("mid", exp_q);
    check("mid_seq_err_post", seq_err, 0);

    // Counter saturation
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_a = '0; in_b = '0;
    repeat (65545) tick();
    check("sat_emit_cnt", emit_cnt, 65535);
    check("sat_seq_err", seq_err, 0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
